frame_deserializer: RTL

FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

---
 rtl/fec_ser_pkg.sv | 13 +
 rtl/frame_deser_obuf.sv | 58 +++++
 rtl/frame_deserializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fec_ser_pkg.sv
// rtl/fec_ser_pkg.sv - shared frame serializer/deserializer types and default sizes
package fec_ser_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DATA_DEPTH = 8;
  localparam int DEF_DIV_WIDTH  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_e;

endpackage

// File: rtl/frame_deser_obuf.sv
// rtl/frame_deser_obuf.sv - frame output buffer with valid/ready handoff and overrun flag
module frame_deser_obuf #(
  parameter int FRAME_W = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               complete_i,
  input  logic               ready_i,
  input  logic               err_clr_i,
  output logic [FRAME_W-1:0] par_o,
  output logic               valid_o,
  output logic               overrun_o
);

  logic [FRAME_W-1:0] par_q, par_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               accept, drop;

  // A completed frame is only taken when the slot is free or is being consumed this cycle.
  assign accept = complete_i && (!valid_q || ready_i);
  assign drop   = complete_i && valid_q && !ready_i;

  always_comb begin
    par_d     = par_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (accept) begin
      par_d   = frame_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end else if (err_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign par_o     = par_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/frame_deserializer.sv
// rtl/frame_deserializer.sv - serial-to-frame deserializer; FRAME_DESER_TIMEOUT_EN adds the inter-bit gap timeout
module frame_deserializer
  import fec_ser_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             serial_in,
  input  logic                             serial_en,
  input  logic [DIV_WIDTH-1:0]             clk_div,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0] par_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(DATA_WIDTH)-1:0]    bit_count,
  output logic [$clog2(DATA_DEPTH)-1:0]    sample_count,
  output logic                             overrun,
  output logic                             timeout_err,
  input  logic                             err_clr
);

  localparam int FW  = DATA_WIDTH * DATA_DEPTH;
  localparam int BCW = $clog2(DATA_WIDTH);
  localparam int SCW = $clog2(DATA_DEPTH);

  deser_state_e   state_q, state_d;
  logic [FW-1:0]  shift_q, shift_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic [SCW-1:0] word_q, word_d;
  logic           complete;

`ifdef FRAME_DESER_TIMEOUT_EN
  localparam int GW = DIV_WIDTH + 3;
  logic [GW-1:0] gap_q, gap_d;
  logic [GW-1:0] gap_limit;
  logic          timeout_evt;
  logic          tmo_q, tmo_d;

  assign gap_limit = {1'b0, clk_div, 2'b00} + GW'(4);
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    word_d   = word_q;
    complete = 1'b0;
`ifdef FRAME_DESER_TIMEOUT_EN
    gap_d       = '0;
    timeout_evt = 1'b0;
`endif
    // MSB-first shifting leaves the first received bit of word 0 at the top of the frame.
    if (serial_en) begin
      shift_d = {shift_q[FW-2:0], serial_in};
      if (bit_q == BCW'(DATA_WIDTH - 1)) begin
        bit_d = '0;
        if (word_q == SCW'(DATA_DEPTH - 1)) begin
          word_d   = '0;
          complete = 1'b1;
        end else begin
          word_d = word_q + SCW'(1);
        end
      end else begin
        bit_d = bit_q + BCW'(1);
      end
      state_d = complete ? IDLE : RECV;
    end
`ifdef FRAME_DESER_TIMEOUT_EN
    else if (state_q == RECV) begin
      if (gap_q + GW'(1) == gap_limit) begin
        timeout_evt = 1'b1;
        state_d     = IDLE;
        shift_d     = '0;
        bit_d       = '0;
        word_d      = '0;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
    end
  end

`ifdef FRAME_DESER_TIMEOUT_EN
  always_comb begin
    tmo_d = tmo_q;
    if (timeout_evt) begin
      tmo_d = 1'b1;
    end else if (err_clr) begin
      tmo_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  logic unused_clk_div;
  assign unused_clk_div = ^clk_div;
  assign timeout_err    = 1'b0;
`endif

  frame_deser_obuf #(
    .FRAME_W(FW)
  ) u_obuf (
    .clk_i     (clk),
    .rst_i     (rst),
    .frame_i   (shift_d),
    .complete_i(complete),
    .ready_i   (out_ready),
    .err_clr_i (err_clr),
    .par_o     (par_out),
    .valid_o   (out_valid),
    .overrun_o (overrun)
  );

  assign bit_count    = bit_q;
  assign sample_count = word_q;

endmodule
